// File: rtl/led_bank_scheduler_if.sv
// Requester-side bundle for led_bank_scheduler: requests, packed values,
// grant/ack handshake and the shared LED bank outputs.
interface led_bank_scheduler_if #(
  parameter int unsigned WIDTH = 4
);
  logic [3:0]         REQ;
  logic [4*WIDTH-1:0] VALS;
  logic [3:0]         GNT;
  logic [3:0]         ACK;
  logic [WIDTH-1:0]   BANK_VAL;
  logic [3:0]         BANK_EN;
  logic               BUSY;

  modport master (
    output REQ, VALS,
    input  GNT, ACK, BANK_VAL, BANK_EN, BUSY
  );

  modport slave (
    input  REQ, VALS,
    output GNT, ACK, BANK_VAL, BANK_EN, BUSY
  );
endinterface

// File: rtl/led_bank_scheduler.sv
// Four-way scheduler sharing the LED bank datapath; round-robin by default,
// fixed lowest-index priority when LED_SCHED_FIXED_PRI_EN is defined.
module led_bank_scheduler #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  led_bank_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_HOLD,
    S_RELEASE
  } state_t;

  state_t           state_q;
  logic [1:0]       win_q;
  logic [1:0]       win_d;
  logic [7:0]       cnt_q;
  logic [3:0]       gnt_q;
  logic [3:0]       ack_q;
  logic [3:0]       bank_en_q;
  logic [WIDTH-1:0] bank_val_q;
  logic             busy_q;
  logic             any_req;

`ifdef LED_SCHED_FIXED_PRI_EN
  always_comb begin
    win_d   = '0;
    any_req = |bus.REQ;
    for (int unsigned k = 4; k > 0; k--) begin
      if (bus.REQ[k-1]) win_d = 2'(k - 1);
    end
  end
`else
  logic [1:0] ptr_q;
  logic [1:0] idx;

  // Walk from the farthest slot back to the pointer so the closest requester wins.
  always_comb begin
    win_d   = ptr_q;
    idx     = ptr_q;
    any_req = |bus.REQ;
    for (int unsigned k = 4; k > 0; k--) begin
      idx = ptr_q + 2'(k - 1);
      if (bus.REQ[idx]) win_d = idx;
    end
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      win_q      <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      bank_en_q  <= '0;
      bank_val_q <= '0;
      busy_q     <= 1'b0;
`ifndef LED_SCHED_FIXED_PRI_EN
      ptr_q      <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (any_req) begin
            win_q   <= win_d;
            gnt_q   <= 4'b0001 << win_d;
            busy_q  <= 1'b1;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          bank_val_q <= bus.VALS[win_q*WIDTH +: WIDTH];
          cnt_q      <= 8'(HOLD_CYCLES - 1);
          bank_en_q  <= gnt_q;
          state_q    <= S_HOLD;
        end
        S_HOLD: begin
          // Abort takes precedence over completion; ACK is armed only on completion.
          if (!bus.REQ[win_q]) begin
            bank_en_q <= '0;
            state_q   <= S_RELEASE;
          end else if (cnt_q == 8'd0) begin
            bank_en_q <= '0;
            ack_q     <= gnt_q;
            state_q   <= S_RELEASE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_RELEASE: begin
          ack_q   <= '0;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
`ifndef LED_SCHED_FIXED_PRI_EN
          ptr_q   <= win_q + 2'd1;
`endif
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.GNT      = gnt_q;
  assign bus.ACK      = ack_q;
  assign bus.BANK_EN  = bank_en_q;
  assign bus.BANK_VAL = bank_val_q;
  assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_led_bank_scheduler.sv
// Scoreboard bench for led_bank_scheduler: stimulus queues expected grants,
// a negedge monitor checks each grant's value, dwell, ack and spacing.
module tb_led_bank_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;

  led_bank_scheduler_if #(.WIDTH(4)) bus ();

  led_bank_scheduler #(
    .WIDTH       (4),
    .HOLD_CYCLES (8)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic [3:0] val;
    int         en_cycles;  // -1: not checked (grant cut by reset)
    bit         ack;
    int         gap;        // 0: not checked
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [3:0] v, input int en, input bit a, input int gap);
    exp_t e;
    e.gnt = g; e.val = v; e.en_cycles = en; e.ack = a; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic wait_gnt(input logic [3:0] mask);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((bus.GNT & mask) == 4'b0) && n < 64);
    if ((bus.GNT & mask) == 4'b0) begin
      n_checks++; n_fail++;
      $display("FAIL gnt_timeout: got 0x%0h required mask 0x%0h", bus.GNT, mask);
    end
  endtask

  task automatic wait_ack(input logic [3:0] mask);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((bus.ACK & mask) == 4'b0) && n < 64);
    if ((bus.ACK & mask) == 4'b0) begin
      n_checks++; n_fail++;
      $display("FAIL ack_timeout: got 0x%0h required mask 0x%0h", bus.ACK, mask);
    end
  endtask

  // Monitor
  initial begin
    exp_t       cur;
    logic [3:0] prev_gnt;
    int         cyc, last, en_cnt, ack_cnt;
    bit         active, val_bad, ack_bad;
    prev_gnt = '0; cyc = 0; last = 0; en_cnt = 0; ack_cnt = 0;
    active = 0; val_bad = 0; ack_bad = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.GNT != 4'b0 && prev_gnt == 4'b0) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_grant: got 0x%0h required none", bus.GNT);
          active = 0;
        end else begin
          cur = sb.pop_front();
          active = 1;
          check("grant_onehot", 32'(bus.GNT), 32'(cur.gnt));
          check("busy_in_grant", 32'(bus.BUSY), 32'd1);
          check("en_low_in_grant", 32'(bus.BANK_EN), 32'd0);
          if (cur.gap > 0) check("grant_spacing", 32'(cyc - last), 32'(cur.gap));
        end
        last = cyc; en_cnt = 0; ack_cnt = 0; val_bad = 0; ack_bad = 0;
      end
      if (active && bus.BANK_EN != 4'b0) begin
        en_cnt++;
        if (bus.BANK_EN !== cur.gnt || bus.BANK_VAL !== cur.val) val_bad = 1;
      end
      if (active && bus.ACK != 4'b0) begin
        ack_cnt++;
        if (bus.ACK !== cur.gnt || bus.BANK_EN != 4'b0) ack_bad = 1;
      end
      if (active && bus.GNT == 4'b0) begin
        if (cur.en_cycles >= 0) begin
          check("bank_en_cycles", 32'(en_cnt), 32'(cur.en_cycles));
          check("bank_val_during_en", 32'(val_bad), 32'd0);
        end
        check("ack_count", 32'(ack_cnt), cur.ack ? 32'd1 : 32'd0);
        check("ack_target", 32'(ack_bad), 32'd0);
        active = 0;
      end
      prev_gnt = bus.GNT;
    end
  end

  // Stimulus
  initial begin
    int n;
    bus.REQ  = '0;
    bus.VALS = '0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(bus.GNT), 32'd0);
    check("rst_ack", 32'(bus.ACK), 32'd0);
    check("rst_bank_val", 32'(bus.BANK_VAL), 32'd0);
    check("rst_bank_en", 32'(bus.BANK_EN), 32'd0);
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Single request, requester 0, value A
    @(posedge clk); #1;
    bus.VALS = 16'h000A;
    bus.REQ  = 4'b0001;
    push(4'b0001, 4'hA, 8, 1, 0);
    wait_ack(4'b0001);
    bus.REQ = '0;
    @(posedge clk); #1;
    check("busy_after_release", 32'(bus.BUSY), 32'd0);

    // Fresh pointer, all four requesting continuously
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    bus.VALS = 16'h4321;
`ifdef LED_SCHED_FIXED_PRI_EN
    push(4'b0001, 4'h1, 8, 1, 0);
    for (int i = 0; i < 4; i++) push(4'b0001, 4'h1, 8, 1, 11);
`else
    push(4'b0001, 4'h1, 8, 1, 0);
    push(4'b0010, 4'h2, 8, 1, 11);
    push(4'b0100, 4'h3, 8, 1, 11);
    push(4'b1000, 4'h4, 8, 1, 11);
    push(4'b0001, 4'h1, 8, 1, 11);
`endif
    bus.REQ = 4'b1111;
    for (int i = 0; i < 5; i++) wait_ack(4'b1111);
    bus.REQ = '0;
    repeat (2) @(posedge clk); #1;

    // Abort requester 2 on its third HOLD cycle; requester 3 follows
    bus.VALS = 16'h9700;
    push(4'b0100, 4'h7, 3, 0, 0);
    push(4'b1000, 4'h9, 8, 1, 6);
    bus.REQ = 4'b1100;
    wait_gnt(4'b0100);
    repeat (3) @(posedge clk);
    #1 bus.REQ[2] = 1'b0;
    wait_ack(4'b1000);
    bus.REQ = '0;
    repeat (2) @(posedge clk); #1;

    // VALS change during HOLD is ignored
    bus.VALS = 16'h0005;
    push(4'b0001, 4'h5, 8, 1, 0);
    bus.REQ = 4'b0001;
    wait_gnt(4'b0001);
    repeat (2) @(posedge clk);
    #1 bus.VALS[3:0] = 4'hF;
    wait_ack(4'b0001);
    bus.REQ = '0;
    repeat (2) @(posedge clk); #1;
    check("bank_val_retained", 32'(bus.BANK_VAL), 32'h5);
    check("idle_gnt", 32'(bus.GNT), 32'd0);
    check("idle_bank_en", 32'(bus.BANK_EN), 32'd0);

    // Reset during HOLD, then pointer restarts at 0
    bus.VALS = 16'h0060;
    push(4'b0010, 4'h6, -1, 0, 0);
    bus.REQ = 4'b0010;
    wait_gnt(4'b0010);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_gnt", 32'(bus.GNT), 32'd0);
    check("midrst_ack", 32'(bus.ACK), 32'd0);
    check("midrst_bank_val", 32'(bus.BANK_VAL), 32'd0);
    check("midrst_bank_en", 32'(bus.BANK_EN), 32'd0);
    check("midrst_busy", 32'(bus.BUSY), 32'd0);
    bus.REQ = 4'b1010;
    push(4'b0010, 4'h6, 8, 1, 0);
    @(negedge clk) rst = 1'b0;
    wait_ack(4'b0010);
    bus.REQ = '0;

    n = 0;
    while (sb.size() != 0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_bank_scheduler.md
# led_bank_scheduler

Round-robin scheduler that shares the 4-bit LED datapath (the `VAL` input feeding the `SUB` instance arrays and their LED banks) between four requesters. Each requester presents a 4-bit value and a request. The block grants one requester at a time, latches its value onto the shared `BANK_VAL` bus, and holds that value for a programmable dwell time. The bank enable for the granted requester is asserted during the dwell. The block sits between software/test requesters and the LED bank array in `top`.

## Interface
- `WIDTH`, 4, width of each requester value and of `BANK_VAL`.
- `HOLD_CYCLES`, 8, dwell length in clock cycles per grant; legal range 1..255.
- `CLK`  input  1  system clock, rising edge.
- `RST`  input  1  reset, asynchronous, active-high.
- `REQ`  input  4  per-requester request; requester i must hold `REQ[i]` until `ACK[i]`.
- `VALS`  input  4*WIDTH  packed request values; requester i uses `VALS[i*WIDTH +: WIDTH]`.
- `GNT`  output  4  one-hot grant; high from GRANT through RELEASE.
- `ACK`  output  4  one-cycle completion pulse to the granted requester.
- `BANK_VAL`  output  WIDTH  latched value driven to the LED datapath `VAL`.
- `BANK_EN`  output  4  one-hot bank enable; high only during HOLD.
- `BUSY`  output  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, GRANT, HOLD, RELEASE.
  - IDLE: if any `REQ` bit is set, pick a winner, register it, and go to GRANT. Otherwise stay.
  - GRANT (1 cycle): latch the winner's slice of `VALS` into `BANK_VAL`, load the dwell counter with `HOLD_CYCLES-1`, and go to HOLD.
  - HOLD: decrement the counter each cycle. At count 0 go to RELEASE with `ack_pending` set. If `REQ[winner]` drops, go to RELEASE immediately with `ack_pending` clear (abort).
  - RELEASE (1 cycle): pulse `ACK[winner]` only if `ack_pending` is set. Advance the round-robin pointer to winner+1 mod 4. Go to IDLE.
- Arbitration: round-robin. Search order starts at the pointer. After reset the pointer is 0, so requester 0 has highest priority first. The pointer advances on both completion and abort.
- `VALS` changes during HOLD are ignored. `BANK_VAL` changes only in GRANT and on reset.
- In IDLE, `BANK_VAL` retains the last latched value. `GNT`, `BANK_EN` and `ACK` are all zero.
- `REQ` changes during GRANT and RELEASE are not acted on. `REQ` is re-evaluated in IDLE only.
- Dwell counter: 8 bits, unsigned. It never wraps because it stops at 0.
- Reset mid-operation forces IDLE at once. All outputs clear, the pointer clears, and no `ACK` is issued for the interrupted grant.

## Timing
- Reset values: `GNT`=0, `ACK`=0, `BANK_VAL`=0, `BANK_EN`=0, `BUSY`=0, state=IDLE, pointer=0, counter=0.
- A request seen in IDLE at edge t produces:
  - `GNT` high and `BUSY` high after edge t (GRANT state);
  - `BANK_VAL` valid and `BANK_EN` high after edge t+1;
  - `BANK_EN` high for exactly `HOLD_CYCLES` cycles;
  - `ACK` high for 1 cycle after edge t+1+`HOLD_CYCLES` (RELEASE);
  - IDLE after edge t+2+`HOLD_CYCLES`.
- Grant-to-grant spacing with back-to-back requests is `HOLD_CYCLES`+3 cycles.
- Abort: when `REQ[winner]` is seen low at a HOLD edge, RELEASE follows on the next cycle. `BANK_EN` drops with that same edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `LED_SCHED_FIXED_PRI_EN`:
  - Defined: arbitration is fixed priority, with the lowest asserted index winning. The pointer is not implemented and is not updated.
  - Undefined (default): round-robin as described above.
- All timing is identical in both builds.

## Test plan
- Reset, then single request: set `REQ`=0001 and `VALS[3:0]`=4'hA with `HOLD_CYCLES`=8. Expect:
  - `GNT`=0001 one cycle after `REQ` is sampled;
  - `BANK_VAL`=4'hA with `BANK_EN`=0001 for exactly 8 cycles;
  - `ACK`=0001 for 1 cycle, then `BUSY`=0 on the next cycle.
- All four requesting continuously (`REQ`=1111) with values 1, 2, 3, 4 → grants in order 0, 1, 2, 3, 0, spaced 11 cycles apart; `BANK_VAL` follows 1, 2, 3, 4, 1.
- Abort: drop `REQ[2]` on the 3rd HOLD cycle → no `ACK`, `BANK_EN` low after that edge, and the next grant goes to requester 3 if it is requesting.
- `VALS` change during HOLD (4'h5 → 4'hF) → `BANK_VAL` stays 4'h5 until the next grant.
- Assert `RST` during HOLD → all outputs 0 asynchronously with no `ACK`; after release, `REQ`=1010 grants requester 1 first (pointer=0).
- Built with `LED_SCHED_FIXED_PRI_EN`, `REQ`=1111 held → requester 0 is granted repeatedly; requesters 1-3 are never granted.
